mult_share_arbiter: RTL and testbench

//  Shares one 2-stage pipelined unsigned multiplier between NUM_REQ requesters.

---
 rtl/mult_share_pkg.sv | 32 +++
 rtl/mult_pipe2.sv | 73 +++++++
 rtl/mult_share_arbiter.sv | 99 +++++++++
 tb/tb_mult_share_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared defaults, types and index helper for the multiplier-sharing arbiter.
// Round-robin arbitration is enabled by defining MULT_SHARE_RR_EN.
package mult_share_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int OP_W_DEF    = 4;
  localparam int ID_W_DEF    = 2;
  localparam int IDX_W       = 4;

  typedef logic [2*OP_W_DEF-1:0] prod_t;
  typedef logic [ID_W_DEF-1:0]   id_t;
  typedef logic [IDX_W-1:0]      idx_t;

  typedef struct packed {
    logic                valid;
    id_t                 id;
    logic [OP_W_DEF-1:0] a;
    logic [OP_W_DEF-1:0] b;
  } stage_t;

  // (base + off) mod n, valid for base, off < n <= 8
  function automatic idx_t wrap_add(
    input idx_t base,
    input idx_t off,
    input idx_t n
  );
    idx_t s;
    s = base + off;
    return (s >= n) ? idx_t'(s - n) : s;
  endfunction

endpackage

// File: rtl/mult_pipe2.sv
// Two-stage unsigned multiplier pipe: operand regs, then product reg,
// with valid and requester-id sideband carried alongside.
module mult_pipe2
  import mult_share_pkg::*;
#(
  parameter int OP_W = OP_W_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ID_W-1:0]   in_id,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              s1_valid,
  output logic              out_valid,
  output logic [ID_W-1:0]   out_id,
  output logic [2*OP_W-1:0] out_product
);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } s1_t;

  s1_t               s1_q, s1_d;
  logic              s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]   s2_id_q, s2_id_d;
  logic [2*OP_W-1:0] s2_prod_q, s2_prod_d;

  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = in_valid;
    if (in_valid) begin
      s1_d.id = in_id;
      s1_d.a  = in_a;
      s1_d.b  = in_b;
    end
  end

  // Bubbles leave id/product holding their last values
  always_comb begin
    s2_valid_d = s1_q.valid;
    s2_id_d    = s2_id_q;
    s2_prod_d  = s2_prod_q;
    if (s1_q.valid) begin
      s2_id_d   = s1_q.id;
      s2_prod_d = (2*OP_W)'(s1_q.a) * (2*OP_W)'(s1_q.b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_prod_q  <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_prod_q  <= s2_prod_d;
    end
  end

  assign s1_valid    = s1_q.valid;
  assign out_valid   = s2_valid_q;
  assign out_id      = s2_id_q;
  assign out_product = s2_prod_q;

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one 2-stage multiplier among NUM_REQ valid/ready requesters.
// MULT_SHARE_RR_EN: round-robin grant; otherwise lowest index wins.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic                    CLK_50,
  input  logic                    Clear_n,
  input  logic                    en,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [2*OP_W-1:0]       rsp_product,
  output logic                    busy
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   gnt;
  idx_t                 base;
  idx_t                 first;
  idx_t                 gidx;
  logic                 hs;
  logic [ID_W-1:0]      sel_id;
  logic [OP_W-1:0]      sel_a;
  logic [OP_W-1:0]      sel_b;
  logic                 s1_valid;

`ifdef MULT_SHARE_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;
  assign base = idx_t'(ptr_q);
`else
  assign base = '0;
`endif

  // Rotate so the search always starts at bit 0, then un-rotate
  always_comb begin
    dbl   = {req_valid, req_valid};
    rot   = NUM_REQ'(dbl >> base);
    first = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) first = idx_t'(k);
    end
    hs   = en && (|req_valid);
    gidx = wrap_add(base, first, idx_t'(NUM_REQ));
    gnt  = hs ? (NUM_REQ'(1) << gidx) : '0;
  end

  always_comb begin
    sel_id = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_id = ID_W'(i);
        sel_a  = req_a[i*OP_W +: OP_W];
        sel_b  = req_b[i*OP_W +: OP_W];
      end
    end
  end

`ifdef MULT_SHARE_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = ID_W'(wrap_add(gidx, idx_t'(1), idx_t'(NUM_REQ)));
  end

  always_ff @(posedge CLK_50 or negedge Clear_n) begin
    if (!Clear_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`endif

  mult_pipe2 #(
    .OP_W (OP_W),
    .ID_W (ID_W)
  ) u_pipe (
    .clk         (CLK_50),
    .rst_n       (Clear_n),
    .in_valid    (hs),
    .in_id       (sel_id),
    .in_a        (sel_a),
    .in_b        (sel_b),
    .s1_valid    (s1_valid),
    .out_valid   (rsp_valid),
    .out_id      (rsp_id),
    .out_product (rsp_product)
  );

  assign req_ready = gnt;
  assign busy      = s1_valid | rsp_valid;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: grant model + response scoreboard,
// plus per-scenario directed checks. Honors MULT_SHARE_RR_EN.
module tb_mult_share_arbiter;

  logic        clk;
  logic        Clear_n;
  logic        en;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_product;
  logic        busy;

  typedef struct {
    logic [1:0] id;
    logic [7:0] prod;
    int         due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   m_ptr  = 0;

  mult_share_arbiter #(
    .NUM_REQ (4),
    .OP_W    (4),
    .ID_W    (2)
  ) dut (
    .CLK_50      (clk),
    .Clear_n     (Clear_n),
    .en          (en),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: grant model, response ordering and latency
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] exp_gnt;
    int idx;
    if (!Clear_n) begin
      q.delete();
      m_ptr = 0;
    end else begin
      if (rsp_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d prod=%0d, none expected", rsp_id, rsp_product);
        end else begin
          e = q.pop_front();
          if (rsp_id !== e.id || rsp_product !== e.prod || cyc != e.due) begin
            errors++;
            $display("FAIL rsp_sb: got id=%0d prod=%0d cyc=%0d, want id=%0d prod=%0d cyc=%0d",
                     rsp_id, rsp_product, cyc, e.id, e.prod, e.due);
          end
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        checks++;
        errors++;
        e = q.pop_front();
        $display("FAIL rsp_missing: got none at cyc=%0d, want id=%0d prod=%0d", cyc, e.id, e.prod);
      end
      exp_gnt = '0;
      if (en) begin
        for (int k = 3; k >= 0; k--) begin
          if (req_valid[(m_ptr + k) % 4]) begin
            exp_gnt = '0;
            exp_gnt[(m_ptr + k) % 4] = 1'b1;
          end
        end
      end
      checks++;
      if (req_ready !== exp_gnt) begin
        errors++;
        $display("FAIL grant_model: got req_ready=%b, want %b", req_ready, exp_gnt);
      end
      for (int i = 0; i < 4; i++) begin
        if (exp_gnt[i]) begin
          idx = i;
          e.id   = 2'(i);
          e.prod = 8'(req_a[idx*4 +: 4]) * 8'(req_b[idx*4 +: 4]);
          e.due  = cyc + 2;
          q.push_back(e);
`ifdef MULT_SHARE_RR_EN
          m_ptr = (i + 1) % 4;
`endif
        end
      end
    end
  end

  task automatic pulse_reset;
    @(posedge clk);
    #3 Clear_n = 1'b0;
    @(posedge clk);
    #3 Clear_n = 1'b1;
  endtask

  task automatic test_reset;
    Clear_n   = 1'b0;
    en        = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_product !== 8'd0
        || busy !== 1'b0 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b id=%0d p=%0d busy=%b rdy=%b, want all 0",
               rsp_valid, rsp_id, rsp_product, busy, req_ready);
    end
    @(posedge clk);
    #3 Clear_n = 1'b1;
    en = 1'b1;
  endtask

  task automatic test_single;
    @(posedge clk);
    #1 req_valid = 4'b0001;
    req_a = 16'h0003;
    req_b = 16'h0005;
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 8'd15) begin
      errors++;
      $display("FAIL single_op: got v=%b id=%0d p=%0d, want v=1 id=0 p=15",
               rsp_valid, rsp_id, rsp_product);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_products;
    logic [3:0] ta[3] = '{4'd15, 4'd0, 4'd7};
    logic [3:0] tb[3] = '{4'd15, 4'd9, 4'd6};
    logic [7:0] tp[3] = '{8'hE1, 8'h00, 8'd42};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 req_valid = 4'b0001;
      req_a = {12'h0, ta[i]};
      req_b = {12'h0, tb[i]};
      @(posedge clk);
      #1 req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_product !== tp[i]) begin
        errors++;
        $display("FAIL product_%0d: got v=%b p=%h, want v=1 p=%h", i, rsp_valid, rsp_product, tp[i]);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || rsp_product !== tp[i] || rsp_id !== 2'd0) begin
        errors++;
        $display("FAIL bubble_hold_%0d: got v=%b p=%h id=%0d, want v=0 p=%h id=0",
                 i, rsp_valid, rsp_product, rsp_id, tp[i]);
      end
    end
  endtask

  task automatic test_arbitration;
    logic [3:0] want;
    pulse_reset();
    req_a = {4'd7, 4'd5, 4'd3, 4'd1};
    req_b = {4'd2, 4'd9, 4'd11, 4'd13};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 req_valid = 4'b1111;
      @(negedge clk);
`ifdef MULT_SHARE_RR_EN
      want = 4'b0001 << (i % 4);
`else
      want = 4'b0001;
`endif
      checks++;
      if (req_ready !== want) begin
        errors++;
        $display("FAIL arb_order_%0d: got %b, want %b", i, req_ready, want);
      end
    end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_en_drain;
    @(posedge clk);
    #1 req_valid = 4'b1111;
    req_a = {4'd4, 4'd6, 4'd8, 4'd10};
    req_b = {4'd3, 4'd3, 4'd3, 4'd3};
    @(posedge clk);
    @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL en_off: got rdy=%b busy=%b, want rdy=0000 busy=1", req_ready, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL en_drain: got busy=%b pending=%0d, want busy=0 pending=0", busy, q.size());
    end
    req_valid = '0;
    en = 1'b1;
  endtask

  task automatic test_reset_mid;
    int seen;
    @(posedge clk);
    #1 req_valid = 4'b0011;
    req_a = {8'h0, 4'd9, 4'd5};
    req_b = {8'h0, 4'd2, 4'd5};
    @(posedge clk);
    @(posedge clk);
    #1 req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_inflight: got busy=%b, want 1", busy);
    end
    #4 Clear_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b busy=%b, want 0 0", rsp_valid, busy);
    end
    @(posedge clk);
    #3 Clear_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stale_rsp: got %0d rsp busy=%b, want 0 rsp busy=0", seen, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] want;
    req_a = {4'd12, 4'd11, 4'd0, 4'd0};
    req_b = {4'd13, 4'd14, 4'd0, 4'd0};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (i < 4) req_valid = (i % 2 == 0) ? 4'b0100 : 4'b1000;
      else       req_valid = '0;
      @(negedge clk);
      if (i >= 2) begin
        want = ((i - 2) % 2 == 0) ? 2'd2 : 2'd3;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== want) begin
          errors++;
          $display("FAIL b2b_%0d: got v=%b id=%0d, want v=1 id=%0d", i - 2, rsp_valid, rsp_id, want);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_products();
    test_arbitration();
    test_en_drain();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
